// File: rtl/rr_arbiter_fsm_if.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter_fsm_if
// Brief    : Request/grant bundle between four requesters and the
//            round-robin arbiter.
// Revision : 1.0  initial release
// ============================================================================
interface rr_arbiter_fsm_if;
  logic [3:0] req;        // one request bit per requester
  logic [3:0] gnt;        // one-hot grant or all-zero
  logic [1:0] gnt_id;     // owner index, 0 when not busy
  logic       busy;       // resource currently granted
  logic       preempted;  // turnaround caused by forced rotation

  // Requester side: drives requests, observes the grant.
  modport master (
    output req,
    input  gnt,
    input  gnt_id,
    input  busy,
    input  preempted
  );

  // Arbiter side: samples requests, drives the grant.
  modport slave (
    input  req,
    output gnt,
    output gnt_id,
    output busy,
    output preempted
  );
endinterface
`default_nettype wire

// File: rtl/rr_arbiter_fsm.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter_fsm
// Brief    : Four-requester round-robin arbiter, Moore FSM with a forced
//            rotation after MAX_HOLD cycles and a one-cycle turnaround
//            between consecutive grants.
// Revision : 1.0  initial release
// ============================================================================
module rr_arbiter_fsm #(
  parameter int MAX_HOLD = 8
) (
  input  wire logic       clk,
  input  wire logic       reset,
  rr_arbiter_fsm_if.slave bus
);

  localparam logic [7:0] c_hold_last = 8'(MAX_HOLD - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_TURN  = 2'd2
  } state_t;

  state_t     r_state;
  logic [1:0] r_ptr;
  logic [1:0] r_owner;
  logic [7:0] r_hold_cnt;
  logic [3:0] r_gnt;
  logic [1:0] r_gnt_id;
  logic       r_busy;
  logic       r_preempted;

  logic [3:0] w_rot;
  logic [1:0] w_offset;
  logic [1:0] w_winner;
  logic [3:0] w_winner_oh;
  logic       w_any_req;
  logic       w_own_req;
  logic       w_others_req;

  // Pick the first requester at or after ptr by rotating req so ptr lands on bit 0.
  always_comb begin
    w_rot = bus.req;
    case (r_ptr)
      2'd0:    w_rot = bus.req;
      2'd1:    w_rot = {bus.req[0],   bus.req[3:1]};
      2'd2:    w_rot = {bus.req[1:0], bus.req[3:2]};
      default: w_rot = {bus.req[2:0], bus.req[3]};
    endcase
    w_offset = 2'd3;
    if (w_rot[0])      w_offset = 2'd0;
    else if (w_rot[1]) w_offset = 2'd1;
    else if (w_rot[2]) w_offset = 2'd2;
    w_winner     = r_ptr + w_offset;
    w_winner_oh  = 4'b0001 << w_winner;
    w_any_req    = |bus.req;
    w_own_req    = bus.req[r_owner];
    w_others_req = |(bus.req & ~(4'b0001 << r_owner));
  end

  // State machine; outputs are registered alongside the state they decode.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_ptr       <= 2'd0;
      r_owner     <= 2'd0;
      r_hold_cnt  <= 8'd0;
      r_gnt       <= 4'b0000;
      r_gnt_id    <= 2'd0;
      r_busy      <= 1'b0;
      r_preempted <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any_req) begin
            r_state    <= ST_GRANT;
            r_owner    <= w_winner;
            r_hold_cnt <= 8'd0;
            r_gnt      <= w_winner_oh;
            r_gnt_id   <= w_winner;
            r_busy     <= 1'b1;
          end
        end
        ST_GRANT: begin
          // Release wins over preempt when both happen on the same edge.
          if (!w_own_req || ((r_hold_cnt == c_hold_last) && w_others_req)) begin
            r_state     <= ST_TURN;
            r_ptr       <= r_owner + 2'd1;
            r_gnt       <= 4'b0000;
            r_gnt_id    <= 2'd0;
            r_busy      <= 1'b0;
            r_preempted <= w_own_req;
          end else if (r_hold_cnt != c_hold_last) begin
            r_hold_cnt <= r_hold_cnt + 8'd1;
          end
        end
        ST_TURN: begin
          r_preempted <= 1'b0;
          if (w_any_req) begin
            r_state    <= ST_GRANT;
            r_owner    <= w_winner;
            r_hold_cnt <= 8'd0;
            r_gnt      <= w_winner_oh;
            r_gnt_id   <= w_winner;
            r_busy     <= 1'b1;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_gnt       <= 4'b0000;
          r_gnt_id    <= 2'd0;
          r_busy      <= 1'b0;
          r_preempted <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gnt       = r_gnt;
  assign bus.gnt_id    = r_gnt_id;
  assign bus.busy      = r_busy;
  assign bus.preempted = r_preempted;

endmodule
`default_nettype wire

// File: doc/rr_arbiter_fsm.md
# rr_arbiter_fsm

Four-requester round-robin arbiter for a single shared resource, built as a Moore state machine with synchronous reset. The arbiter grants the resource to one requester at a time and keeps the grant until the requester releases it. It forcibly rotates ownership after MAX_HOLD cycles if another requester is waiting. A mandatory one-cycle turnaround separates consecutive grants, so the resource is never driven by two owners on adjacent cycles.

## Interface
- MAX_HOLD, default 8: maximum consecutive grant cycles while another requester waits; legal range 2..255.
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  reset, synchronous, active-high.
- req  input  4  request per requester; bit i = requester i.
- gnt  output  4  one-hot grant, or all-zero; decoded from state only (Moore).
- gnt_id  output  2  index of current owner; valid when busy=1, 0 otherwise.
- busy  output  1  high in GRANT state.
- preempted  output  1  high for the TURN cycle entered via forced rotation; 0 otherwise.

## Operation
- States:
  - IDLE: no grant.
  - GRANT: resource owned by requester `owner`.
  - TURN: one-cycle turnaround, no grant.
- Internal registers:
  - ptr[1:0]: round-robin priority pointer.
  - owner[1:0]: current owner.
  - hold_cnt, 8-bit: grant cycles already elapsed.
- Winner selection: the first i with req[i]=1 in the order ptr, ptr+1, ptr+2, ptr+3 (mod 4).
- IDLE:
  - If req≠0: go to GRANT, owner=winner, hold_cnt=0.
  - Otherwise: stay in IDLE.
- GRANT (owner = i):
  - If req[i]=0: go to TURN (release), preempted=0, ptr=i+1 mod 4.
  - Else if hold_cnt==MAX_HOLD-1 and (req & ~(1<<i))≠0: go to TURN (preempt), preempted=1, ptr=i+1 mod 4.
  - Else: stay in GRANT. hold_cnt increments, saturating at MAX_HOLD-1.
  - Release takes precedence over preempt when both conditions hold in the same cycle.
- TURN:
  - Always lasts exactly one cycle; preempted is cleared on exit.
  - If req≠0: go to GRANT with a fresh winner from the updated ptr, hold_cnt=0.
  - Otherwise: go to IDLE.
- Sole requester: it keeps the grant indefinitely. hold_cnt saturates; no preempt occurs.
- A preempted requester that keeps req high re-enters arbitration at lowest priority, which the updated ptr guarantees.
- Requesters may assert or deassert req on any cycle. Only the value sampled at the rising edge matters; there is no req-stability requirement.

## Timing
- Reset values: state=IDLE, ptr=0, owner=0, hold_cnt=0, gnt=4'b0000, gnt_id=0, busy=0, preempted=0.
- Reset asserted mid-grant: gnt=0 on the cycle after the reset edge, with no TURN cycle. Reset overrides every transition.
- Request-to-grant latency:
  - From IDLE: req sampled high at edge k → gnt valid from edge k to the next edge (1 cycle).
  - From TURN: the TURN cycle adds 1 cycle.
- Release latency: req[i] sampled low at edge k → gnt=0 from edge k. The requester therefore sees gnt for one cycle after deasserting req.
- With a competitor waiting, a held grant lasts exactly MAX_HOLD cycles, followed by exactly 1 TURN cycle.
- gnt, gnt_id, busy and preempted are all registered-state decodes. None has a combinational path from req.
- No two consecutive cycles carry grants to different owners.

## Test plan
- Reset then idle: reset=1 for 2 cycles, req=0 → all outputs 0 throughout; state stays IDLE.
- Single request, release: req=0001 from cycle 1, dropped after 3 grant cycles.
  - gnt=0001 for cycles 2–5.
  - TURN at cycle 6, then IDLE; ptr=1.
- Preempt rotation (MAX_HOLD=4): req=0011 held constantly after reset.
  - gnt=0001 for 4 cycles, 0 for 1 cycle (preempted=1), 0010 for 4 cycles, 0 for 1 cycle, then 0001 again; pattern repeats.
- Fairness: req=1111 constant, MAX_HOLD=2 → gnt_id sequence 0,1,2,3,0 with each grant lasting 2 cycles and 1-cycle gaps.
- Release/preempt tie: owner 0, hold_cnt=MAX_HOLD-1, req changes 0011→0010 on the same edge → TURN with preempted=0, then gnt=0010.
- Mid-grant reset: assert reset while gnt=0100 → gnt=0 on the next cycle; after release, req=0100 is granted with ptr=0 ordering; no TURN cycle is seen.
